bpss_wr_sched: RTL and testbench

//  Shares one descriptor-bypass write-request channel (bpss_wr_req/bpss_wr_done)

---
 rtl/bpss_wr_sched.sv | 161 ++++++++++++++++
 tb/tb_bpss_wr_sched.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bpss_wr_sched.sv
// bpss_wr_sched: round-robin share of one bypass write-request channel with credit cap and in-order completion routing.
// Optional WR_SCHED_STATS_EN adds stat_issued/stat_done counters.
module bpss_wr_sched #(
    parameter int N_REQ      = 4,
    parameter int MAX_OUT    = 16,
    parameter int VADDR_BITS = 48,
    parameter int LEN_BITS   = 28,
    parameter int PID_BITS   = 6
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [N_REQ-1:0]               s_req_valid,
    output logic [N_REQ-1:0]               s_req_ready,
    input  logic [N_REQ*VADDR_BITS-1:0]    s_req_vaddr,
    input  logic [N_REQ*LEN_BITS-1:0]      s_req_len,
    input  logic [N_REQ-1:0]               s_req_ctl,
    input  logic [N_REQ*PID_BITS-1:0]      s_req_pid,
    output logic                           m_req_valid,
    input  logic                           m_req_ready,
    output logic [VADDR_BITS-1:0]          m_req_vaddr,
    output logic [LEN_BITS-1:0]            m_req_len,
    output logic                           m_req_ctl,
    output logic [PID_BITS-1:0]            m_req_pid,
    input  logic                           s_done_valid,
    output logic                           s_done_ready,
    output logic [N_REQ-1:0]               done_pulse,
    output logic [$clog2(MAX_OUT):0]       outstanding,
    output logic                           err_sticky
`ifdef WR_SCHED_STATS_EN
    ,
    output logic [31:0]                    stat_issued,
    output logic [31:0]                    stat_done
`endif
);
    localparam int IW = $clog2(N_REQ);
    localparam int AW = $clog2(MAX_OUT);
    localparam int OW = AW + 1;

    logic [IW-1:0]         ptr_q, ptr_d, grant;
    logic                  found, accept, pop;
    logic                  m_valid_q, m_valid_d, m_ctl_q, m_ctl_d, err_q, err_d;
    logic [VADDR_BITS-1:0] m_vaddr_q, m_vaddr_d;
    logic [LEN_BITS-1:0]   m_len_q, m_len_d;
    logic [PID_BITS-1:0]   m_pid_q, m_pid_d;
    logic [N_REQ-1:0]      pulse_q, pulse_d;
    logic [OW-1:0]         out_q, out_d;
    logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [IW-1:0]         fifo_q [MAX_OUT];
    logic [IW-1:0]         fifo_d [MAX_OUT];

    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            int j;
            j = (int'(ptr_q) + k) % N_REQ;
            if (!found && s_req_valid[j]) begin
                found = 1'b1;
                grant = IW'(j);
            end
        end
    end

    // credit check uses the registered count, so a same-cycle completion cannot unblock a grant
    assign accept      = found && (!m_valid_q || m_req_ready) && (out_q < OW'(MAX_OUT));
    assign pop         = s_done_valid && (out_q != '0);
    assign s_req_ready = accept ? (N_REQ'(1) << grant) : '0;

    always_comb begin
        ptr_d     = ptr_q;
        m_valid_d = m_valid_q;
        m_vaddr_d = m_vaddr_q;
        m_len_d   = m_len_q;
        m_ctl_d   = m_ctl_q;
        m_pid_d   = m_pid_q;
        fifo_d    = fifo_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        pulse_d   = '0;
        err_d     = err_q | (s_done_valid && out_q == '0);
        out_d     = out_q + OW'(accept) - OW'(pop);
        if (accept) begin
            ptr_d          = grant;
            m_valid_d      = 1'b1;
            m_vaddr_d      = s_req_vaddr[grant*VADDR_BITS +: VADDR_BITS];
            m_len_d        = s_req_len[grant*LEN_BITS +: LEN_BITS];
            m_ctl_d        = s_req_ctl[grant];
            m_pid_d        = s_req_pid[grant*PID_BITS +: PID_BITS];
            fifo_d[wptr_q] = grant;
            wptr_d         = wptr_q + 1'b1;
        end else if (m_req_ready) begin
            m_valid_d = 1'b0;
        end
        if (pop) begin
            pulse_d = N_REQ'(1) << fifo_q[rptr_q];
            rptr_d  = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q     <= IW'(N_REQ - 1);
            m_valid_q <= 1'b0;
            m_vaddr_q <= '0;
            m_len_q   <= '0;
            m_ctl_q   <= 1'b0;
            m_pid_q   <= '0;
            for (int i = 0; i < MAX_OUT; i++) fifo_q[i] <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            pulse_q   <= '0;
            out_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            m_valid_q <= m_valid_d;
            m_vaddr_q <= m_vaddr_d;
            m_len_q   <= m_len_d;
            m_ctl_q   <= m_ctl_d;
            m_pid_q   <= m_pid_d;
            fifo_q    <= fifo_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            pulse_q   <= pulse_d;
            out_q     <= out_d;
            err_q     <= err_d;
        end
    end

    assign m_req_valid  = m_valid_q;
    assign m_req_vaddr  = m_vaddr_q;
    assign m_req_len    = m_len_q;
    assign m_req_ctl    = m_ctl_q;
    assign m_req_pid    = m_pid_q;
    assign s_done_ready = 1'b1;
    assign done_pulse   = pulse_q;
    assign outstanding  = out_q;
    assign err_sticky   = err_q;

`ifdef WR_SCHED_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d, stat_done_q, stat_done_d;

    always_comb begin
        stat_issued_d = stat_issued_q + 32'(m_valid_q && m_req_ready);
        stat_done_d   = stat_done_q + 32'(pop);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_issued_q <= '0;
            stat_done_q   <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_done_q   <= stat_done_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_done   = stat_done_q;
`endif
endmodule

// File: tb/tb_bpss_wr_sched.sv
// tb_bpss_wr_sched: randomized traffic checked against a queue-based reference model.
module tb_bpss_wr_sched;
    localparam int N  = 4;
    localparam int MO = 16;
    localparam int VB = 48;
    localparam int LB = 28;
    localparam int PB = 6;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [N-1:0]    s_req_valid = '0;
    logic [N-1:0]    s_req_ready;
    logic [N*VB-1:0] s_req_vaddr = '0;
    logic [N*LB-1:0] s_req_len = '0;
    logic [N-1:0]    s_req_ctl = '0;
    logic [N*PB-1:0] s_req_pid = '0;
    logic            m_req_valid;
    logic            m_req_ready = 1'b0;
    logic [VB-1:0]   m_req_vaddr;
    logic [LB-1:0]   m_req_len;
    logic            m_req_ctl;
    logic [PB-1:0]   m_req_pid;
    logic            s_done_valid = 1'b0;
    logic            s_done_ready;
    logic [N-1:0]    done_pulse;
    logic [4:0]      outstanding;
    logic            err_sticky;
`ifdef WR_SCHED_STATS_EN
    logic [31:0]     stat_issued, stat_done;
    int              e_issued, e_done;
`endif

    bpss_wr_sched #(.N_REQ(N), .MAX_OUT(MO), .VADDR_BITS(VB), .LEN_BITS(LB), .PID_BITS(PB)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_vaddr(s_req_vaddr), .s_req_len(s_req_len), .s_req_ctl(s_req_ctl), .s_req_pid(s_req_pid),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_vaddr(m_req_vaddr), .m_req_len(m_req_len), .m_req_ctl(m_req_ctl), .m_req_pid(m_req_pid),
        .s_done_valid(s_done_valid), .s_done_ready(s_done_ready),
        .done_pulse(done_pulse), .outstanding(outstanding), .err_sticky(err_sticky)
`ifdef WR_SCHED_STATS_EN
        , .stat_issued(stat_issued), .stat_done(stat_done)
`endif
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    // reference model: issued-requester queue plus the visible output slot
    int             order_q[$];
    int             ptr;
    bit             e_valid, e_ctl, e_err;
    logic [VB-1:0]  e_vaddr;
    logic [LB-1:0]  e_len;
    logic [PB-1:0]  e_pid;
    logic [N-1:0]   e_pulse;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        order_q.delete();
        ptr = N - 1;
        e_valid = 0; e_ctl = 0; e_err = 0;
        e_vaddr = '0; e_len = '0; e_pid = '0; e_pulse = '0;
`ifdef WR_SCHED_STATS_EN
        e_issued = 0; e_done = 0;
`endif
    endtask

    task automatic check_regs();
        check("m_valid", 64'(m_req_valid), 64'(e_valid));
        if (e_valid) begin
            check("m_vaddr", 64'(m_req_vaddr), 64'(e_vaddr));
            check("m_len", 64'(m_req_len), 64'(e_len));
            check("m_ctl", 64'(m_req_ctl), 64'(e_ctl));
            check("m_pid", 64'(m_req_pid), 64'(e_pid));
        end
        check("done_pulse", 64'(done_pulse), 64'(e_pulse));
        check("outstanding", 64'(outstanding), 64'(order_q.size()));
        check("err_sticky", 64'(err_sticky), 64'(e_err));
        check("s_done_ready", 64'(s_done_ready), 64'd1);
`ifdef WR_SCHED_STATS_EN
        check("stat_issued", 64'(stat_issued), 64'(e_issued));
        check("stat_done", 64'(stat_done), 64'(e_done));
`endif
    endtask

    task automatic cycle(input int pv, input int pr, input int pd);
        int g;
        @(negedge aclk);
        check_regs();
        for (int i = 0; i < N; i++) begin
            s_req_valid[i]           = ($urandom_range(99) < pv);
            s_req_vaddr[i*VB +: VB]  = VB'({$urandom, $urandom});
            s_req_len[i*LB +: LB]    = ($urandom_range(7) == 0) ? '0 : LB'($urandom);
            s_req_ctl[i]             = $urandom_range(1);
            s_req_pid[i*PB +: PB]    = PB'($urandom);
        end
        m_req_ready  = ($urandom_range(99) < pr);
        s_done_valid = ($urandom_range(99) < pd);
        #1;
        g = -1;
        if ((!e_valid || m_req_ready) && order_q.size() < MO)
            for (int k = 1; k <= N; k++)
                if (g < 0 && s_req_valid[(ptr + k) % N]) g = (ptr + k) % N;
        check("s_req_ready", 64'(s_req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
`ifdef WR_SCHED_STATS_EN
        if (e_valid && m_req_ready) e_issued++;
`endif
        e_pulse = '0;
        if (s_done_valid) begin
            if (order_q.size() > 0) begin
                e_pulse = N'(1) << order_q.pop_front();
`ifdef WR_SCHED_STATS_EN
                e_done++;
`endif
            end else e_err = 1;
        end
        if (g >= 0) begin
            order_q.push_back(g);
            ptr = g;
            e_valid = 1;
            e_vaddr = s_req_vaddr[g*VB +: VB];
            e_len   = s_req_len[g*LB +: LB];
            e_ctl   = s_req_ctl[g];
            e_pid   = s_req_pid[g*PB +: PB];
        end else if (m_req_ready) e_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        s_req_valid = '0; m_req_ready = 1'b0; s_done_valid = 1'b0;
        model_reset();
        #1;
        check_regs();
        check("rst_ready", 64'(s_req_ready), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic run(input int n, input int pv, input int pr, input int pd);
        for (int i = 0; i < n; i++) cycle(pv, pr, pd);
    endtask

    initial begin
        model_reset();
        do_reset();
        run(200, 70, 70, 40);
        run(30, 100, 100, 0);
        run(40, 100, 100, 60);
        run(20, 60, 0, 0);
        run(200, 50, 50, 50);
        run(40, 100, 100, 100);
        do_reset();
        run(10, 0, 100, 100);
        run(150, 40, 60, 45);
        do_reset();
        run(100, 80, 30, 30);
        @(negedge aclk);
        check_regs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
